// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared widths, command encoding and FSM states for the DRAM stub
package dram_pkg;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 128;
    localparam int MASK_W = 16;

    typedef enum logic [2:0] {
        CMD_WRITE = 3'b000,
        CMD_READ  = 3'b001
    } cmd_e;

    typedef enum logic [1:0] {
        ST_CALIB,
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_RESP
    } state_e;

endpackage

// File: rtl/dram_stub_mem.sv
// rtl/dram_stub_mem.sv - byte-maskable word storage with a registered read port
module dram_stub_mem
    import dram_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [MASK_W-1:0]     wr_mask,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [DATA_W-1:0]     rd_data
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rd_data_q;

    // Contents deliberately have no reset so they survive a controller reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MASK_W; i++) begin
            if (wr_en && !wr_mask[i]) begin
                mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
            end
        end
        rd_data_q <= mem[rd_idx];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dram_stub.sv
// rtl/dram_stub.sv - single-outstanding-read DRAM model with calibration delay
module dram_stub
    import dram_pkg::*;
#(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 8,
    parameter int CALIB_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_cmd,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [MASK_W-1:0] req_mask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              calib_done
);

    localparam int CAL_W = $clog2(CALIB_CYCLES + 1);

    state_e                  state_q, state_d;
    logic [CAL_W-1:0]        cal_cnt_q, cal_cnt_d;
    logic                    calib_done_q, calib_done_d;
    logic [7:0]              lat_cnt_q, lat_cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
    logic                    wr_en;
    logic                    accept;
    logic [DEPTH_LOG2-1:0]   req_idx;
    logic [DATA_W-1:0]       mem_rd_data;
    logic                    unused_addr_bits;

    assign req_idx          = req_addr[3 +: DEPTH_LOG2];
    assign unused_addr_bits = ^{req_addr[2:0], req_addr[ADDR_W-1:DEPTH_LOG2+3]};
    assign req_ready        = (state_q == ST_IDLE);
    assign accept           = req_valid && req_ready;

    always_comb begin
        state_d      = state_q;
        cal_cnt_d    = cal_cnt_q;
        calib_done_d = calib_done_q;
        lat_cnt_d    = lat_cnt_q;
        idx_d        = idx_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        wr_en        = 1'b0;
        case (state_q)
            ST_CALIB: begin
                cal_cnt_d = cal_cnt_q + CAL_W'(1);
                if (cal_cnt_q == CAL_W'(CALIB_CYCLES - 1)) begin
                    calib_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    if (cmd_e'(req_cmd) == CMD_WRITE) begin
                        wr_en = 1'b1;
                    end else if (cmd_e'(req_cmd) == CMD_READ) begin
                        idx_d     = req_idx;
                        lat_cnt_d = 8'(READ_LATENCY - 1);
                        state_d   = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (lat_cnt_q == 8'd0) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = mem_rd_data;
                    state_d     = ST_RD_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 8'd1;
                end
            end
            ST_RD_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_CALIB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CALIB;
            cal_cnt_q    <= '0;
            calib_done_q <= 1'b0;
            lat_cnt_q    <= '0;
            idx_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            cal_cnt_q    <= cal_cnt_d;
            calib_done_q <= calib_done_d;
            lat_cnt_q    <= lat_cnt_d;
            idx_q        <= idx_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // Read address follows idx_d so the word is fetched on the acceptance edge.
    dram_stub_mem #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (req_idx),
        .wr_data (req_data),
        .wr_mask (req_mask),
        .rd_idx  (idx_d),
        .rd_data (mem_rd_data)
    );

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign calib_done = calib_done_q;

endmodule

// File: doc/dram_stub.md
DRAM_STUB -- requirements
Module: dram_stub

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: the stub holds 2^DEPTH_LOG2 data words of 128 bits.
REQ-002 Parameter READ_LATENCY, default 8: cycles from read acceptance to rsp_valid; legal range 1..255.
REQ-003 Parameter CALIB_CYCLES, default 16: cycles from reset release to calib_done.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_valid  in  1  a command is presented.
REQ-007 req_ready  out  1  the stub accepts a command this cycle.
REQ-008 req_cmd  in  3  command: 3'b000 write, 3'b001 read.
REQ-009 req_addr  in  27  address in 16-bit units; one 128-bit word spans 8 addresses.
REQ-010 req_data  in  128  write data.
REQ-011 req_mask  in  16  byte mask; bit i = 1 means byte i is not written.
REQ-012 rsp_valid  out  1  read data is presented.
REQ-013 rsp_ready  in  1  the requester takes the read data.
REQ-014 rsp_data  out  128  read data.
REQ-015 calib_done  out  1  the stub is ready for commands.

Function
REQ-016 A command is accepted on a rising edge where req_valid && req_ready.
REQ-017 The word index is req_addr[3 +: DEPTH_LOG2]; higher address bits are ignored, so addresses wrap modulo the depth; req_addr[2:0] are ignored.
REQ-018 calib_done is 0 from reset and rises after exactly CALIB_CYCLES clk cycles; it then stays 1 until the next reset.
REQ-019 The FSM has four states: CALIB, IDLE, RD_WAIT and RD_RESP.
REQ-020 The FSM moves CALIB->IDLE when calib_done rises.
REQ-021 The FSM stays in IDLE on an accepted write.
REQ-022 The FSM moves IDLE->RD_WAIT on an accepted read.
REQ-023 The FSM moves RD_WAIT->RD_RESP when the latency counter reaches 0.
REQ-024 The FSM moves RD_RESP->IDLE on rsp_valid && rsp_ready.
REQ-025 req_ready is 1 only in IDLE; it is combinational from the state only, not from req_valid.
REQ-026 An accepted write updates every byte whose mask bit is 0; the update is visible to any read accepted on a later cycle.
REQ-027 An accepted read latches the word index and loads the latency counter with READ_LATENCY-1.
REQ-028 When the latency counter reaches 0, the stub samples the memory word into rsp_data, and rsp_valid rises exactly READ_LATENCY cycles after the acceptance edge.
REQ-029 rsp_valid and rsp_data hold stable until the rsp handshake completes; rsp_ready while rsp_valid=0 has no effect.
REQ-030 The stub has one outstanding read at most; no command is accepted from read acceptance until the response handshake completes.
REQ-031 A command with any other req_cmd value is accepted and ignored; the state stays IDLE and memory is unchanged.
REQ-032 A write to an index followed by a read of the same index on the next cycle returns the new data.

Reset
REQ-033 While rst_n=0, the state is CALIB and the calibration counter is cleared.
REQ-034 While rst_n=0, these outputs are 0: req_ready, rsp_valid, rsp_data and calib_done.
REQ-035 A reset mid-read drops the pending response; no rsp_valid appears after reset release.
REQ-036 Memory contents are not reset; they are retained across reset and are undefined before the first write.

Structure
REQ-037 Package dram_pkg holds ADDR_W=27, DATA_W=128, MASK_W=16 and the command enum (CMD_WRITE=3'b000, CMD_READ=3'b001).
REQ-038 Byte-write storage is the sub-module dram_stub_mem: synchronous write with byte enables and a registered read port.
REQ-039 Latency and calibration counters, the FSM and the handshake logic live in dram_stub.

Verification
REQ-040 Calibration: release reset -> calib_done=0 and req_ready=0 for 16 cycles, then both are 1.
REQ-041 Write then read: write 0x0123..CDEF at addr 0x40 with mask 0, then read 0x40 -> rsp_valid 8 cycles after acceptance, rsp_data equals the written value.
REQ-042 Byte mask: write all-ones to addr 0, then all-zeros with mask 16'h00FF, then read addr 0 -> upper 8 bytes 0x00, lower 8 bytes 0xFF.
REQ-043 Backpressure: read with rsp_ready=0 for 20 cycles -> rsp_valid and rsp_data stay stable and req_ready=0 throughout; when rsp_ready=1, one handshake occurs, then req_ready=1.
REQ-044 Wrap: write at index 0, then read at addr 8<<DEPTH_LOG2 -> returns the index-0 data.
REQ-045 Reset mid-read: assert rst_n=0 during RD_WAIT -> no rsp_valid after release, and recalibration repeats.
